trs_cmd_stream_loader: RTL



---
 rtl/trs_cmd_stream_loader.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/trs_cmd_stream_loader.sv
// rtl/trs_cmd_stream_loader.sv - TRS-80 /CMD image parser with buffered RAM write port
module trs_cmd_stream_loader #(
    parameter int ADDR_W     = 24,
    parameter int LOAD_BASE  = 0,
    parameter int FIFO_DEPTH = 4,
    parameter int INDEX      = 2
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              ioctl_download,
    input  logic [7:0]        ioctl_index,
    input  logic              ioctl_wr,
    input  logic [7:0]        ioctl_dout,
    output logic              ioctl_wait,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_data,
    input  logic              mem_ready,
    output logic              loader_download,
    output logic [15:0]       execute_addr,
    output logic              execute_enable,
    output logic              error
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_TYPE,
        S_LEN,
        S_ADLO,
        S_ADHI,
        S_DATA,
        S_SLEN,
        S_SKIP,
        S_XLEN,
        S_XLO,
        S_XHI,
        S_DONE,
        S_ERR,
        S_FINISH
    } state_t;

    state_t            state;
    state_t            cur_state;
    logic              sel;
    logic              sel_q;
    logic              sel_rise;
    logic              sel_fall;
    logic              accept;
    logic              data_push;
    logic              xfer_seen;
    logic [8:0]        cnt;
    logic [15:0]       rec_addr;

    logic              pend_valid;
    logic [ADDR_W-1:0] pend_addr;
    logic [7:0]        pend_data;

    logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
    logic [7:0]        fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_next;
    logic [CNT_W:0]    occ_next;
    logic              pop;
    logic              fifo_idle;

    // Download selection and byte acceptance; a byte arriving with the rising edge is parsed as a type byte
    always_comb begin
        sel       = ioctl_download && (ioctl_index == 8'(INDEX));
        sel_rise  = sel && !sel_q;
        sel_fall  = !sel && sel_q;
        accept    = sel && ioctl_wr;
        cur_state = sel_rise ? S_TYPE : state;
        data_push = accept && (cur_state == S_DATA);
    end

    // FIFO head presentation and occupancy bookkeeping (staged byte counts as occupied)
    always_comb begin
        mem_wr     = (count != '0);
        mem_addr   = mem_wr ? fifo_addr[rd_ptr] : '0;
        mem_data   = mem_wr ? fifo_data[rd_ptr] : '0;
        pop        = mem_wr && mem_ready;
        count_next = count + CNT_W'(pend_valid) - CNT_W'(pop);
        occ_next   = {1'b0, count_next} + (CNT_W + 1)'(data_push);
        fifo_idle  = (count == '0) && !pend_valid;
    end

    // Record parser: one transition per accepted byte, end-of-load checks and start pulse
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state           <= S_IDLE;
            sel_q           <= 1'b0;
            loader_download <= 1'b0;
            error           <= 1'b0;
            execute_addr    <= 16'h0000;
            execute_enable  <= 1'b0;
            xfer_seen       <= 1'b0;
            cnt             <= 9'd0;
            rec_addr        <= 16'h0000;
        end else begin
            sel_q          <= sel;
            execute_enable <= 1'b0;
            if (sel_rise) begin
                error           <= 1'b0;
                execute_addr    <= 16'h0000;
                xfer_seen       <= 1'b0;
                loader_download <= 1'b1;
                state           <= S_TYPE;
            end
            if (sel_fall) begin
                // Anything other than a record boundary or a terminal state means the image was cut short
                if (state inside {S_LEN, S_ADLO, S_ADHI, S_DATA, S_SLEN, S_SKIP, S_XLEN, S_XLO, S_XHI}) begin
                    error <= 1'b1;
                end
                state <= S_FINISH;
            end else if (cur_state == S_FINISH) begin
                if (fifo_idle) begin
                    loader_download <= 1'b0;
                    execute_enable  <= xfer_seen && !error;
                    state           <= S_IDLE;
                end
            end else if (accept) begin
                case (cur_state)
                    S_TYPE: begin
                        if (ioctl_dout == 8'h01) begin
                            state <= S_LEN;
                        end else if (ioctl_dout == 8'h02) begin
                            state <= S_XLEN;
                        end else if ((ioctl_dout == 8'h00) || (ioctl_dout >= 8'h20)) begin
                            state <= S_ERR;
                            error <= 1'b1;
                        end else begin
                            state <= S_SLEN;
                        end
                    end
                    S_LEN: begin
                        // Lengths 0..2 encode 256..258; two of those bytes are the load address
                        cnt   <= ((ioctl_dout < 8'd3) ? {1'b1, ioctl_dout} : {1'b0, ioctl_dout}) - 9'd2;
                        state <= S_ADLO;
                    end
                    S_ADLO: begin
                        rec_addr[7:0] <= ioctl_dout;
                        state         <= S_ADHI;
                    end
                    S_ADHI: begin
                        rec_addr[15:8] <= ioctl_dout;
                        state          <= S_DATA;
                    end
                    S_DATA: begin
                        rec_addr <= rec_addr + 16'd1;
                        cnt      <= cnt - 9'd1;
                        state    <= (cnt == 9'd1) ? S_TYPE : S_DATA;
                    end
                    S_SLEN: begin
                        cnt   <= (ioctl_dout == 8'd0) ? 9'd256 : {1'b0, ioctl_dout};
                        state <= S_SKIP;
                    end
                    S_SKIP: begin
                        cnt   <= cnt - 9'd1;
                        state <= (cnt == 9'd1) ? S_TYPE : S_SKIP;
                    end
                    S_XLEN: begin
                        state <= S_XLO;
                    end
                    S_XLO: begin
                        execute_addr[7:0] <= ioctl_dout;
                        state             <= S_XHI;
                    end
                    S_XHI: begin
                        execute_addr[15:8] <= ioctl_dout;
                        xfer_seen          <= 1'b1;
                        state              <= S_DONE;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // Stage a decoded data byte for one cycle before it enters the FIFO
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            pend_valid <= 1'b0;
            pend_addr  <= '0;
            pend_data  <= 8'h00;
        end else begin
            pend_valid <= data_push;
            if (data_push) begin
                pend_addr <= ADDR_W'(LOAD_BASE) + ADDR_W'(rec_addr);
                pend_data <= ioctl_dout;
            end
        end
    end

    // FIFO storage write
    always_ff @(posedge clk_sys) begin
        if (pend_valid) begin
            fifo_addr[wr_ptr] <= pend_addr;
            fifo_data[wr_ptr] <= pend_data;
        end
    end

    // FIFO pointers, count and stall request; stall keeps one slot for a byte already in flight
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            ioctl_wait <= 1'b0;
        end else begin
            if (pend_valid) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count      <= count_next;
            ioctl_wait <= (occ_next >= (CNT_W + 1)'(FIFO_DEPTH - 1));
        end
    end

endmodule
